// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO constants, clog2 helper and the FIFO_TH_CHECK configuration sanity macro
`ifndef FIFO_TH_CHECK
`define FIFO_TH_CHECK(d, af, ae) (((d) >= 4) && (((d) & ((d) - 1)) == 0) && ((af) >= 1) && ((af) <= (d)) && ((ae) >= 0) && ((ae) < (d)))
`endif
package fifo_pkg;
  localparam int UART_DATA_W = 8;
  localparam int UART_DEPTH  = 16;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_W register array, synchronous write, asynchronous read
module fifo_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  // storage is deliberately not reset
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with level flags, sticky errors and flush; SYNC_FIFO_FWFT_EN selects first-word-fall-through reads
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = UART_DATA_W,
  parameter int DEPTH     = UART_DEPTH,
  parameter int AFULL_TH  = DEPTH - 4,
  parameter int AEMPTY_TH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        wr_en,
  input  logic [DATA_W-1:0]           din,
  input  logic                        rd_en,
  output logic [DATA_W-1:0]           dout,
  output logic                        dout_valid,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [clog2(DEPTH):0]       count,
  output logic                        overflow,
  output logic                        underflow
);
  localparam int ADDR_W = clog2(DEPTH);
  localparam logic [ADDR_W:0] AF = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0] AE = (ADDR_W+1)'(AEMPTY_TH);

  if (!`FIFO_TH_CHECK(DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_cfg_err
    $error("sync_fifo_param: DEPTH must be a power of two >= 4 and thresholds in range");
  end

  logic [ADDR_W:0]   wr_ptr, rd_ptr;
  logic [DATA_W-1:0] rdata;
  logic              wr_acc, rd_acc;

  assign wr_acc       = wr_en && !full;
  assign rd_acc       = rd_en && !empty;
  assign count        = wr_ptr - rd_ptr;
  assign empty        = wr_ptr == rd_ptr;
  assign full         = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) && (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign almost_full  = count >= AF;
  assign almost_empty = count <= AE;

  fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (wr_acc && !flush),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (din),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rdata)
  );

  // pointers and sticky error flags; flush outranks any request in the same cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && full) overflow <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end

`ifdef SYNC_FIFO_FWFT_EN
  // head word falls through; masked to zero while empty so reset shows a clean bus
  assign dout       = empty ? '0 : rdata;
  assign dout_valid = !empty;
`else
  logic [DATA_W-1:0] dout_r;
  logic              dv_r;
  // registered read: capture head on an accepted pop, valid pulses for one cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dout_r <= '0;
      dv_r   <= 1'b0;
    end else begin
      dv_r <= rd_acc && !flush;
      if (rd_acc && !flush) dout_r <= rdata;
    end
  assign dout       = dout_r;
  assign dout_valid = dv_r;
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed self-checking bench for sync_fifo_param (DATA_W=8, DEPTH=16, AFULL_TH=12, AEMPTY_TH=2)
module tb_sync_fifo_param;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] din = 8'h00;
  logic       rd_en = 1'b0;
  logic [7:0] dout;
  logic       dout_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  int errs = 0;
  int checks = 0;

  sync_fifo_param #(.DATA_W(8), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .wr_en        (wr_en),
    .din          (din),
    .rd_en        (rd_en),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_count"}, 32'(count), 0);
    chk({tag, "_empty"}, 32'(empty), 1);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_aempty"}, 32'(almost_empty), 1);
    chk({tag, "_afull"}, 32'(almost_full), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_udf"}, 32'(underflow), 0);
    chk({tag, "_dout"}, 32'(dout), 0);
    chk({tag, "_dvalid"}, 32'(dout_valid), 0);
  endtask

  initial begin
    tick;
    tick;
    chk_reset_state("reset");
    rst_n = 1'b1;
    tick;
    // fill and drain
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      din = 8'(i);
      tick;
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_afull", 32'(almost_full), 32'((i + 1) >= 12));
      chk("fill_aempty", 32'(almost_empty), 32'((i + 1) <= 2));
    end
    wr_en = 1'b0;
    chk("fill_full", 32'(full), 1);
    for (int i = 0; i < 16; i++) begin
      rd_en = 1'b1;
      tick;
      chk("drain_data", 32'(dout), 32'(i));
      chk("drain_valid", 32'(dout_valid), 1);
    end
    rd_en = 1'b0;
    chk("drain_empty", 32'(empty), 1);
    chk("drain_full", 32'(full), 0);
    tick;
    chk("drain_valid_low", 32'(dout_valid), 0);
    // overflow with simultaneous read
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1;
      din = 8'(8'h10 + i);
      tick;
    end
    wr_en = 1'b1;
    rd_en = 1'b1;
    din = 8'hAA;
    tick;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_count", 32'(count), 15);
    chk("ovf_rdata", 32'(dout), 32'h10);
    tick;
    chk("ovf_sticky", 32'(overflow), 1);
    for (int i = 1; i < 16; i++) begin
      rd_en = 1'b1;
      tick;
      chk("ovf_drain", 32'(dout), 32'(8'h10 + i));
    end
    rd_en = 1'b0;
    chk("ovf_empty", 32'(empty), 1);
    // underflow with simultaneous write
    wr_en = 1'b1;
    rd_en = 1'b1;
    din = 8'h55;
    tick;
    wr_en = 1'b0;
    chk("udf_flag", 32'(underflow), 1);
    chk("udf_count", 32'(count), 1);
    chk("udf_no_valid", 32'(dout_valid), 0);
    tick;
    rd_en = 1'b0;
    chk("udf_rdata", 32'(dout), 32'h55);
    chk("udf_rvalid", 32'(dout_valid), 1);
    chk("udf_sticky", 32'(underflow), 1);
    // streaming across the pointer wrap at count 5
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1;
      din = 8'(8'h60 + i);
      tick;
    end
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'b1;
      rd_en = 1'b1;
      din = 8'(8'h65 + i);
      tick;
      chk("wrap_count", 32'(count), 5);
      chk("wrap_data", 32'(dout), 32'(8'h60 + i));
      chk("wrap_valid", 32'(dout_valid), 1);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd_en = 1'b1;
      tick;
      chk("wrap_tail", 32'(dout), 32'(8'h88 + i));
    end
    rd_en = 1'b0;
    chk("wrap_empty", 32'(empty), 1);
    // flush beats a write and clears the sticky overflow
    for (int i = 0; i < 9; i++) begin
      wr_en = 1'b1;
      din = 8'(8'h90 + i);
      tick;
    end
    chk("flush_pre_count", 32'(count), 9);
    chk("flush_pre_ovf", 32'(overflow), 1);
    flush = 1'b1;
    wr_en = 1'b1;
    din = 8'hEE;
    tick;
    flush = 1'b0;
    wr_en = 1'b0;
    chk("flush_count", 32'(count), 0);
    chk("flush_empty", 32'(empty), 1);
    chk("flush_ovf", 32'(overflow), 0);
    chk("flush_udf", 32'(underflow), 0);
    tick;
    chk("flush_dropped", 32'(count), 0);
    wr_en = 1'b1;
    din = 8'h77;
    tick;
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick;
    rd_en = 1'b0;
    chk("flush_after_data", 32'(dout), 32'h77);
    // asynchronous reset mid-stream
    for (int i = 0; i < 7; i++) begin
      wr_en = 1'b1;
      din = 8'(8'hA0 + i);
      tick;
    end
    wr_en = 1'b0;
    chk("rst_pre_count", 32'(count), 7);
    rst_n = 1'b0;
    #1;
    chk_reset_state("async_rst");
    tick;
    rst_n = 1'b1;
    tick;
    wr_en = 1'b1;
    din = 8'h3C;
    tick;
    wr_en = 1'b0;
    chk("rst_post_count", 32'(count), 1);
    rd_en = 1'b1;
    tick;
    rd_en = 1'b0;
    chk("rst_post_data", 32'(dout), 32'h3C);
    chk("rst_post_valid", 32'(dout_valid), 1);
    chk("rst_post_empty", 32'(empty), 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
